md5_ctrl: RTL and testbench

Sequencer and chaining-state owner for the iterative MD5 round datapath. Holds the 16-word message block buffer and the four 32-bit chaining registers. Steps the datapath through 64 operations (4 rounds × 16), supplying per step the round, step index, message word and shift amount. Folds the datapath result back into the chaining value, so multi-block messages hash back-to-back.

---
 rtl/md5_ctrl_if.sv | 27 ++
 rtl/md5_ctrl.sv | 91 +++++++++
 tb/tb_md5_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/md5_ctrl_if.sv
// md5_ctrl_if: host/datapath bus of the MD5 sequencer; the slave modport is the controller side.
interface md5_ctrl_if;
    logic wr_en_i;
    logic [3:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic init_i;
    logic start_i;
    logic ready_o;
    logic busy_o;
    logic load_o;
    logic step_en_o;
    logic [1:0] round_o;
    logic [5:0] step_idx_o;
    logic [31:0] msg_word_o;
    logic [4:0] shift_o;
    logic [31:0] dp_a_i, dp_b_i, dp_c_i, dp_d_i;
    logic [127:0] h_o;
    logic done_o;
    modport slave (
        input wr_en_i, wr_addr_i, wr_data_i, init_i, start_i, dp_a_i, dp_b_i, dp_c_i, dp_d_i,
        output ready_o, busy_o, load_o, step_en_o, round_o, step_idx_o, msg_word_o, shift_o, h_o, done_o
    );
    modport master (
        output wr_en_i, wr_addr_i, wr_data_i, init_i, start_i, dp_a_i, dp_b_i, dp_c_i, dp_d_i,
        input ready_o, busy_o, load_o, step_en_o, round_o, step_idx_o, msg_word_o, shift_o, h_o, done_o
    );
endinterface

// File: rtl/md5_ctrl.sv
// md5_ctrl: MD5 step sequencer, message buffer and chaining-value owner.
// Define MD5_CTRL_BSWAP_EN to byte-reverse stored message words and output digest words.
module md5_ctrl #(
    parameter logic [31:0] IV_A = 32'h67452301,
    parameter logic [31:0] IV_B = 32'hEFCDAB89,
    parameter logic [31:0] IV_C = 32'h98BADCFE,
    parameter logic [31:0] IV_D = 32'h10325476
) (
    input logic clk_i,
    input logic rst_i,
    md5_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, ADD = 2'd2, DONE = 2'd3;
    localparam logic [15:0][4:0] SHIFTS = {
        5'd21, 5'd15, 5'd10, 5'd6, 5'd23, 5'd16, 5'd11, 5'd4,
        5'd20, 5'd14, 5'd9, 5'd5, 5'd22, 5'd17, 5'd12, 5'd7
    };

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [1:0] state;
    logic [5:0] n;
    logic [31:0] h_a, h_b, h_c, h_d;
    logic [31:0] buf_q [16];
    logic [3:0] i, g;
    logic [31:0] wdata;
    logic [127:0] hv;
    logic idle;

    assign idle = state == IDLE;
    assign i = n[3:0];
    assign g = n[5:4] == 2'd0 ? i :
               n[5:4] == 2'd1 ? 4'd5 * i + 4'd1 :
               n[5:4] == 2'd2 ? 4'd3 * i + 4'd5 : 4'd7 * i;
    // init with start must hand the datapath IV in the very cycle it loads
    assign hv = (idle && bus.init_i) ? {IV_A, IV_B, IV_C, IV_D} : {h_a, h_b, h_c, h_d};

`ifdef MD5_CTRL_BSWAP_EN
    assign wdata = bswap(bus.wr_data_i);
    assign bus.h_o = {bswap(hv[127:96]), bswap(hv[95:64]), bswap(hv[63:32]), bswap(hv[31:0])};
`else
    assign wdata = bus.wr_data_i;
    assign bus.h_o = hv;
`endif

    assign bus.ready_o = idle;
    assign bus.busy_o = !idle;
    assign bus.load_o = idle && bus.start_i;
    assign bus.step_en_o = state == RUN;
    assign bus.done_o = state == DONE;
    assign bus.round_o = n[5:4];
    assign bus.step_idx_o = n;
    assign bus.msg_word_o = buf_q[g];
    assign bus.shift_o = SHIFTS[{n[5:4], n[1:0]}];

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            state <= IDLE;
            n <= '0;
            {h_a, h_b, h_c, h_d} <= {IV_A, IV_B, IV_C, IV_D};
        end else case (state)
            IDLE: begin
                if (bus.init_i) {h_a, h_b, h_c, h_d} <= {IV_A, IV_B, IV_C, IV_D};
                if (bus.start_i) begin
                    state <= RUN;
                    n <= '0;
                end
            end
            RUN: begin
                n <= n + 6'd1;
                if (n == 6'd63) state <= ADD;
            end
            ADD: begin
                h_a <= h_a + bus.dp_a_i;
                h_b <= h_b + bus.dp_b_i;
                h_c <= h_c + bus.dp_c_i;
                h_d <= h_d + bus.dp_d_i;
                state <= DONE;
            end
            default: state <= IDLE;
        endcase

    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) begin
            for (int k = 0; k < 16; k++) buf_q[k] <= '0;
        end else if (idle && bus.wr_en_i) begin
            buf_q[bus.wr_addr_i] <= wdata;
        end
endmodule

// File: tb/tb_md5_ctrl.sv
// tb_md5_ctrl: directed bench for md5_ctrl with a reference MD5 datapath and a saturating stub.
module tb_md5_ctrl;
    localparam logic [127:0] IV = 128'h67452301EFCDAB8998BADCFE10325476;
    localparam logic [127:0] EMPTY = 128'hD98C1DD404B2008F980980E97E42F8EC;
    localparam logic [127:0] H1 = 128'h67452300EFCDAB8898BADCFD10325475;
    localparam logic [127:0] H2 = 128'h674522FFEFCDAB8798BADCFC10325474;

    logic clk = 0;
    logic rst_n = 0;
    logic stub = 0;
    int total = 0;
    int bad = 0;
    logic [31:0] k_tab [64];
    logic [31:0] ma, mb, mc, md, f_v, t_v;
    logic [127:0] hl;

    md5_ctrl_if bus();
    md5_ctrl dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [127:0] hsw(input logic [127:0] x);
`ifdef MD5_CTRL_BSWAP_EN
        logic [127:0] y;
        for (int w = 0; w < 16; w++) y[w*8 +: 8] = x[(w ^ 3)*8 +: 8];
        return y;
`else
        return x;
`endif
    endfunction

    assign bus.dp_a_i = stub ? 32'hFFFFFFFF : ma;
    assign bus.dp_b_i = stub ? 32'hFFFFFFFF : mb;
    assign bus.dp_c_i = stub ? 32'hFFFFFFFF : mc;
    assign bus.dp_d_i = stub ? 32'hFFFFFFFF : md;

    // reference datapath: loads from h_o, performs one MD5 step per step_en_o
    always @(posedge clk) begin
        if (bus.load_o) begin
            hl = hsw(bus.h_o);
            {ma, mb, mc, md} <= hl;
        end else if (bus.step_en_o) begin
            f_v = bus.round_o == 2'd0 ? (mb & mc) | (~mb & md) :
                  bus.round_o == 2'd1 ? (md & mb) | (~md & mc) :
                  bus.round_o == 2'd2 ? mb ^ mc ^ md : mc ^ (mb | ~md);
            t_v = ma + f_v + k_tab[bus.step_idx_o] + bus.msg_word_o;
            ma <= md;
            md <= mc;
            mc <= mb;
            mb <= mb + ((t_v << bus.shift_o) | (t_v >> (6'd32 - {1'b0, bus.shift_o})));
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en_i = 1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        @(negedge clk);
        bus.wr_en_i = 0;
    endtask

    task automatic go(input logic ini, input logic hold, input string tag);
        int c = 0;
        bus.start_i = 1;
        bus.init_i = ini;
        #1;
        chk({tag, "_load"}, 128'(bus.load_o), 128'd1);
        do begin
            @(negedge clk);
            c++;
            if (!hold) bus.start_i = 0;
            bus.init_i = 0;
        end while (!bus.done_o && c < 200);
        chk({tag, "_lat"}, 128'(c), 128'd66);
    endtask

    initial begin
        real r;
        int c;
        for (int j = 0; j < 64; j++) begin
            r = $sin(real'(j + 1));
            if (r < 0.0) r = -r;
            k_tab[j] = 32'(longint'($floor(r * 4294967296.0)));
        end
        {bus.wr_en_i, bus.init_i, bus.start_i} = '0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(bus.ready_o), 128'd1);
        chk("rst_ctl", 128'({bus.busy_o, bus.load_o, bus.step_en_o, bus.done_o}), 128'd0);
        chk("rst_idx", 128'({bus.round_o, bus.step_idx_o}), 128'd0);
        chk("rst_shift", 128'(bus.shift_o), 128'd7);
        chk("rst_msg", 128'(bus.msg_word_o), 128'd0);
        chk("rst_h", bus.h_o, hsw(IV));
        rst_n = 1;
        @(negedge clk);

        // step sequencing with buffer[k] = k
        for (int k = 0; k < 16; k++) wr(4'(k), 32'(k));
        bus.start_i = 1;
        @(negedge clk);
        bus.start_i = 0;
        for (int s = 0; s < 64; s++) begin
            if (s < 16) chk("seq_lo", 128'(bus.msg_word_o), 128'(s));
            case (s)
                16: chk("seq16", 128'(bus.msg_word_o), 128'd1);
                17: chk("seq17", 128'(bus.msg_word_o), 128'd6);
                32: chk("seq32", 128'(bus.msg_word_o), 128'd5);
                33: chk("seq33", 128'(bus.msg_word_o), 128'd8);
                48: chk("seq48", 128'(bus.msg_word_o), 128'd0);
                49: chk("seq49", 128'(bus.msg_word_o), 128'd7);
                default: ;
            endcase
            if (s == 0) chk("sh0", 128'(bus.shift_o), 128'd7);
            if (s == 17) chk("sh17", 128'(bus.shift_o), 128'd9);
            if (s == 34) chk("sh34", 128'(bus.shift_o), 128'd16);
            if (s == 51) chk("sh51", 128'(bus.shift_o), 128'd21);
            if (s == 63) chk("idx63", 128'({bus.step_en_o, bus.round_o, bus.step_idx_o}), 128'h1FF);
            @(negedge clk);
        end
        chk("add_ctl", 128'({bus.step_en_o, bus.done_o, bus.ready_o}), 128'd0);
        @(negedge clk);
        chk("done_pulse", 128'(bus.done_o), 128'd1);
        @(negedge clk);
        chk("ready_again", 128'({bus.ready_o, bus.done_o}), 128'b10);

        // empty message, init and start together
`ifdef MD5_CTRL_BSWAP_EN
        wr(4'd0, 32'h80000000);
`else
        wr(4'd0, 32'h00000080);
`endif
        for (int k = 1; k < 16; k++) wr(4'(k), 32'd0);
        chk("stored_w0", 128'(bus.msg_word_o), 128'h80);
        bus.start_i = 1;
        bus.init_i = 1;
        #1 chk("init_load_h", bus.h_o, hsw(IV));
        go(1'b1, 1'b0, "empty");
        chk("empty_h", bus.h_o, hsw(EMPTY));

        // busy gating: write/start/init pulses during RUN are ignored
        @(negedge clk);
        bus.init_i = 1;
        @(negedge clk);
        bus.init_i = 0;
        chk("init_only_h", bus.h_o, hsw(IV));
        bus.start_i = 1;
        @(negedge clk);
        bus.start_i = 0;
        repeat (10) @(negedge clk);
        {bus.wr_en_i, bus.start_i, bus.init_i} = 3'b111;
        bus.wr_addr_i = 4'd3;
        bus.wr_data_i = 32'hFFFFFFFF;
        @(negedge clk);
        {bus.wr_en_i, bus.start_i, bus.init_i} = 3'b000;
        c = 12;
        while (!bus.done_o && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("gate_lat", 128'(c), 128'd66);
        chk("gate_h", bus.h_o, hsw(EMPTY));
        @(negedge clk);
        @(negedge clk);
        chk("no_restart", 128'({bus.ready_o, bus.step_en_o}), 128'b10);

        // two-block chaining, start held high through the first block
        stub = 1;
        go(1'b1, 1'b1, "c1");
        chk("c1_h", bus.h_o, hsw(H1));
        @(negedge clk);
        go(1'b0, 1'b0, "c2");
        chk("c2_h", bus.h_o, hsw(H2));
        stub = 0;

        // reset mid-RUN at step 30
        @(negedge clk);
        bus.start_i = 1;
        @(negedge clk);
        bus.start_i = 0;
        repeat (30) @(negedge clk);
        chk("pre_rst_idx", 128'(bus.step_idx_o), 128'd30);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_ctl", 128'({bus.ready_o, bus.step_en_o, bus.busy_o}), 128'b100);
        chk("mid_rst_h", bus.h_o, hsw(IV));
        chk("mid_rst_out", 128'({bus.step_idx_o, bus.shift_o, bus.msg_word_o}), 128'({6'd0, 5'd7, 32'd0}));
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        go(1'b0, 1'b0, "post_rst");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
